// File: rtl/mc_cpu_core.sv
// mc_cpu_core: multi-cycle core for the 16-bit TSC ISA subset.
// One registered FSM (INIT/FETCH/DECODE/EXEC/MEM/WB/HALT) sequences every instruction.
// Memory accesses use a ready handshake; an optional wait limit halts the core with a fault.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   readM, writeM       memory read / write request (decoded from state only)
//   address             memory address, valid while readM|writeM
//   data                bidirectional bus, driven by the core only while writeM=1
//   mem_ready           memory completes the current access this cycle
//   num_inst            retired-instruction count
//   output_port         value of the last WWD
//   is_halted, fault    core stopped (HLT or timeout) / stopped by timeout
module mc_cpu_core #(
  parameter int unsigned          WORD_SIZE  = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC   = '0,
  parameter int unsigned          WAIT_LIMIT = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  input  logic                 mem_ready,
  output logic [WORD_SIZE-1:0] num_inst,
  output logic [WORD_SIZE-1:0] output_port,
  output logic                 is_halted,
  output logic                 fault
);
  localparam int unsigned  W       = WORD_SIZE;
  localparam logic [W-1:0] WordOne = {{(W-1){1'b0}}, 1'b1};

  localparam logic [3:0] OpBne = 4'd0, OpBeq = 4'd1, OpAdi = 4'd4, OpLhi = 4'd6;
  localparam logic [3:0] OpLwd = 4'd7, OpSwd = 4'd8, OpJmp = 4'd9, OpRtype = 4'd15;
  localparam logic [5:0] FnAdd = 6'd0, FnSub = 6'd1, FnAnd = 6'd2, FnOrr = 6'd3;
  localparam logic [5:0] FnNot = 6'd4, FnWwd = 6'd28, FnHlt = 6'd29;

  typedef enum logic [2:0] {StInit, StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] pc_q, pc_d, alu_q, alu_d, mdr_q, mdr_d;
  logic [W-1:0] num_inst_q, num_inst_d, out_q, out_d;
  logic [W-1:0] regs_q [4];
  logic [W-1:0] regs_d [4];
  logic [15:0]  ir_q, ir_d;
  logic         fault_q, fault_d;
  logic [31:0]  wait_q, wait_d;
  logic         retire, timeout;

  logic [3:0]   opcode;
  logic [1:0]   rs, rt, rd;
  logic [5:0]   func;
  logic [7:0]   imm;
  logic [11:0]  target;
  logic [W-1:0] rs_val, rt_val, sext_imm, alu_res;

  assign opcode   = ir_q[15:12];
  assign rs       = ir_q[11:10];
  assign rt       = ir_q[9:8];
  assign rd       = ir_q[7:6];
  assign func     = ir_q[5:0];
  assign imm      = ir_q[7:0];
  assign target   = ir_q[11:0];
  assign rs_val   = regs_q[rs];
  assign rt_val   = regs_q[rt];
  assign sext_imm = {{(W-8){imm[7]}}, imm};

  // The access that sees its WAIT_LIMIT-th consecutive not-ready cycle aborts.
  assign timeout = (WAIT_LIMIT != 0) && !mem_ready && (wait_q == 32'(WAIT_LIMIT) - 32'd1);

  always_comb begin
    alu_res = '0;
    unique case (opcode)
      OpAdi:   alu_res = rs_val + sext_imm;
      OpLhi:   alu_res[15:0] = {imm, 8'h00};
      OpRtype: begin
        unique case (func)
          FnAdd:   alu_res = rs_val + rt_val;
          FnSub:   alu_res = rs_val - rt_val;
          FnAnd:   alu_res = rs_val & rt_val;
          FnOrr:   alu_res = rs_val | rt_val;
          FnNot:   alu_res = ~rs_val;
          default: alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    alu_d      = alu_q;
    mdr_d      = mdr_q;
    num_inst_d = num_inst_q;
    out_d      = out_q;
    regs_d     = regs_q;
    ir_d       = ir_q;
    fault_d    = fault_q;
    retire     = 1'b0;
    readM      = 1'b0;
    writeM     = 1'b0;
    address    = pc_q;
    wait_d     = ((state_q == StFetch || state_q == StMem) && !mem_ready) ? wait_q + 32'd1 : '0;

    unique case (state_q)
      StInit: state_d = StFetch;
      StFetch: begin
        readM = 1'b1;
        if (mem_ready) begin
          ir_d    = data[15:0];
          pc_d    = pc_q + WordOne;
          state_d = StDecode;
        end else if (timeout) begin
          fault_d = 1'b1;
          state_d = StHalt;
        end
      end
      StDecode: begin
        state_d = StExec;
        if (opcode == OpJmp) begin
          pc_d    = {pc_q[W-1:12], target};
          retire  = 1'b1;
          state_d = StFetch;
        end else if (opcode == OpRtype && func == FnWwd) begin
          out_d   = rs_val;
          retire  = 1'b1;
          state_d = StFetch;
        end else if (opcode == OpRtype && func == FnHlt) begin
          retire  = 1'b1;
          state_d = StHalt;
        end else if (!(opcode inside {OpBne, OpBeq, OpAdi, OpLhi, OpLwd, OpSwd}) &&
                     !(opcode == OpRtype && func <= FnNot)) begin
          // Undefined encodings retire as NOPs here.
          retire  = 1'b1;
          state_d = StFetch;
        end
      end
      StExec: begin
        if (opcode == OpBne || opcode == OpBeq) begin
          // pc already points past the branch.
          if ((rs_val == rt_val) == (opcode == OpBeq)) pc_d = pc_q + sext_imm;
          retire  = 1'b1;
          state_d = StFetch;
        end else if (opcode == OpLwd || opcode == OpSwd) begin
          alu_d   = rs_val + sext_imm;
          state_d = StMem;
        end else begin
          alu_d   = alu_res;
          state_d = StWb;
        end
      end
      StMem: begin
        address = alu_q;
        readM   = (opcode == OpLwd);
        writeM  = (opcode != OpLwd);
        if (mem_ready) begin
          if (opcode == OpLwd) begin
            mdr_d   = data;
            state_d = StWb;
          end else begin
            retire  = 1'b1;
            state_d = StFetch;
          end
        end else if (timeout) begin
          fault_d = 1'b1;
          state_d = StHalt;
        end
      end
      StWb: begin
        regs_d[(opcode == OpRtype) ? rd : rt] = (opcode == OpLwd) ? mdr_q : alu_q;
        retire  = 1'b1;
        state_d = StFetch;
      end
      StHalt: state_d = StHalt;
      default: state_d = StInit;
    endcase

    if (retire) num_inst_d = num_inst_q + WordOne;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StInit;
      pc_q       <= RESET_PC;
      alu_q      <= '0;
      mdr_q      <= '0;
      num_inst_q <= '0;
      out_q      <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
      ir_q       <= '0;
      fault_q    <= 1'b0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      alu_q      <= alu_d;
      mdr_q      <= mdr_d;
      num_inst_q <= num_inst_d;
      out_q      <= out_d;
      for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
      ir_q       <= ir_d;
      fault_q    <= fault_d;
      wait_q     <= wait_d;
    end
  end

  assign data        = writeM ? rt_val : 'z;
  assign num_inst    = num_inst_q;
  assign output_port = out_q;
  assign is_halted   = (state_q == StHalt);
  assign fault       = fault_q;
endmodule

// File: tb/tb_mc_cpu_core.sv
// Bench for mc_cpu_core: directed scenarios followed by random programs checked
// against an instruction-level reference interpreter.
module tb_mc_cpu_core;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_ready = 1'b1;
  logic        readM, writeM, is_halted, fault;
  logic [15:0] address, num_inst, output_port;
  wire  [15:0] data;

  logic [15:0] mem [0:65535];
  logic [15:0] mm  [0:65535];
  logic [32:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc, waits, m_cycles, m_retired;
  logic [15:0] m_out;
  bit          chk_bus = 0;

  mc_cpu_core #(.WORD_SIZE(16), .RESET_PC(16'h0000), .WAIT_LIMIT(8)) dut (
    .clk(clk), .reset(reset), .readM(readM), .writeM(writeM), .address(address),
    .data(data), .mem_ready(mem_ready), .num_inst(num_inst), .output_port(output_port),
    .is_halted(is_halted), .fault(fault)
  );

  assign data = readM ? mem[address] : 16'hzzzz;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    logic wr;
    logic [15:0] wa, wd;
    logic [32:0] e;
    wr = writeM && mem_ready;
    wa = address;
    wd = data;
    if (chk_bus && (readM || writeM)) begin
      if (!mem_ready) waits++;
      else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL bus_extra observed=%0h expected=none", address);
      end else begin
        e = exp_q.pop_front();
        chk("bus", {writeM, address, writeM ? data : 16'h0000}, e);
      end
    end
    @(posedge clk);
    if (wr) mem[wa] = wd;
    #1;
    cyc++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] a,
                                      input logic [1:0] b, input logic [7:0] lo);
    return {op, a, b, lo};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
  endtask

  // ISA-level interpreter: expected bus trace, retire count, output and zero-wait cycles.
  task automatic run_model();
    logic [15:0] r [4];
    logic [15:0] pc, ins, a, sx;
    logic [1:0]  s, t, dd;
    mm = mem;
    for (int i = 0; i < 4; i++) r[i] = 16'h0;
    pc = 16'h0; m_cycles = 1; m_retired = 0; m_out = 16'h0;
    exp_q.delete();
    for (int k = 0; k < 2000; k++) begin
      ins = mm[pc];
      exp_q.push_back({1'b0, pc, 16'h0});
      pc = pc + 16'd1;
      s = ins[11:10]; t = ins[9:8]; dd = ins[7:6];
      sx = {{8{ins[7]}}, ins[7:0]};
      m_retired++;
      case (ins[15:12])
        4'd9: begin pc = {pc[15:12], ins[11:0]}; m_cycles += 2; end
        4'd0: begin if (r[s] != r[t]) pc = pc + sx; m_cycles += 3; end
        4'd1: begin if (r[s] == r[t]) pc = pc + sx; m_cycles += 3; end
        4'd4: begin r[t] = r[s] + sx; m_cycles += 4; end
        4'd6: begin r[t] = {ins[7:0], 8'h00}; m_cycles += 4; end
        4'd7: begin
          a = r[s] + sx;
          exp_q.push_back({1'b0, a, 16'h0});
          r[t] = mm[a];
          m_cycles += 5;
        end
        4'd8: begin
          a = r[s] + sx;
          exp_q.push_back({1'b1, a, r[t]});
          mm[a] = r[t];
          m_cycles += 4;
        end
        4'd15: begin
          case (ins[5:0])
            6'd0: begin r[dd] = r[s] + r[t]; m_cycles += 4; end
            6'd1: begin r[dd] = r[s] - r[t]; m_cycles += 4; end
            6'd2: begin r[dd] = r[s] & r[t]; m_cycles += 4; end
            6'd3: begin r[dd] = r[s] | r[t]; m_cycles += 4; end
            6'd4: begin r[dd] = ~r[s]; m_cycles += 4; end
            6'd28: begin m_out = r[s]; m_cycles += 2; end
            6'd29: begin m_cycles += 2; return; end
            default: m_cycles += 2;
          endcase
        end
        default: m_cycles += 2;
      endcase
    end
  endtask

  task automatic run_random(input int n);
    logic [15:0] ins;
    logic [1:0]  ra, rb, rdd, d;
    logic [7:0]  im;
    int          zero_run;
    clear_mem();
    for (int i = 16'h3F80; i < 16'h4080; i++) mem[i] = 16'($urandom);
    mem[0] = enc(4'd6, 2'd0, 2'd3, 8'h40);  // r3 = 0x4000, base for loads/stores
    for (int i = 1; i <= n; i++) begin
      ra = 2'($urandom_range(0, 3)); rb = 2'($urandom_range(0, 3));
      rdd = 2'($urandom_range(0, 2)); d = 2'($urandom_range(0, 2)); im = 8'($urandom);
      case ($urandom_range(0, 9))
        0: ins = enc(4'd15, ra, rb, {rdd, 6'($urandom_range(0, 4))});
        1, 9: ins = enc(4'd4, ra, d, im);
        2: ins = enc(4'd6, ra, d, im);
        3: ins = enc(4'd7, 2'd3, d, im);
        4: ins = enc(4'd8, 2'd3, rb, im);
        5: ins = enc(4'd15, ra, rb, {rdd, 6'd28});
        6: ins = enc(4'($urandom_range(0, 1)), ra, rb, 8'($urandom_range(0, 3)));
        7: ins = {4'd9, 12'(i + 1 + int'($urandom_range(0, 3)))};
        default: begin
          if ($urandom_range(0, 1) == 1) ins = {4'($urandom_range(10, 14)), 12'($urandom)};
          else ins = enc(4'd15, ra, rb, {rdd, 6'($urandom_range(5, 27))});
        end
      endcase
      mem[i] = ins;
    end
    for (int i = 1; i <= 3; i++) mem[n + i] = 16'h2000;
    mem[n + 4] = enc(4'd8, 2'd3, 2'd0, 8'h00);
    mem[n + 5] = enc(4'd8, 2'd3, 2'd1, 8'h01);
    mem[n + 6] = enc(4'd8, 2'd3, 2'd2, 8'h02);
    mem[n + 7] = 16'hF41C;
    mem[n + 8] = 16'hF01D;
    run_model();

    reset = 1'b1; mem_ready = 1'b1;
    ticks(2);
    reset = 1'b0;
    cyc = 0; waits = 0; zero_run = 0; chk_bus = 1;
    while (!is_halted && cyc < 4000) begin
      if (zero_run < 4 && $urandom_range(0, 3) == 0) begin
        mem_ready = 1'b0; zero_run++;
      end else begin
        mem_ready = 1'b1; zero_run = 0;
      end
      tick();
    end
    chk_bus = 0;
    mem_ready = 1'b1;
    chk("rnd_halted", is_halted, 1'b1);
    chk("rnd_fault", fault, 1'b0);
    chk("rnd_cycles", cyc, m_cycles + waits);
    chk("rnd_num_inst", num_inst, 16'(m_retired));
    chk("rnd_output", output_port, m_out);
    chk("rnd_bus_left", exp_q.size(), 0);
  endtask

  initial begin
    clear_mem();
    mem[16'h00] = 16'h4105;  // ADI r1,r0,5
    mem[16'h01] = 16'hF41C;  // WWD r1
    mem[16'h02] = 16'h4207;  // ADI r2,r0,7
    mem[16'h03] = 16'h1002;  // BEQ r0,r0,+2
    mem[16'h06] = 16'h0005;  // BNE r0,r0,+5 (not taken)
    mem[16'h07] = 16'hF81C;  // WWD r2
    mem[16'h08] = 16'h8110;  // SWD r1,r0,0x10
    mem[16'h09] = 16'h7210;  // LWD r2,r0,0x10
    mem[16'h0A] = 16'hF81C;  // WWD r2
    mem[16'h0B] = 16'h90A0;  // JMP 0x0A0
    mem[16'hA0] = 16'h6112;  // LHI r1,0x12
    mem[16'hA1] = 16'hF41C;  // WWD r1
    mem[16'hA2] = 16'hF4C4;  // NOT r3 = ~r1
    mem[16'hA3] = 16'hFC1C;  // WWD r3
    mem[16'hA4] = 16'h2000;  // undefined -> NOP
    mem[16'hA5] = 16'hF01D;  // HLT

    // Reset state and INIT cycle
    reset = 1'b1; mem_ready = 1'b1;
    ticks(2);
    chk("rst_readM", readM, 1'b0);
    chk("rst_writeM", writeM, 1'b0);
    chk("rst_num_inst", num_inst, 16'h0);
    chk("rst_halted", is_halted, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_output", output_port, 16'h0);
    reset = 1'b0;
    chk("init_readM", readM, 1'b0);
    tick();
    chk("fetch0_readM", readM, 1'b1);
    chk("fetch0_addr", address, 16'h0000);

    // ADI then WWD, zero waits
    ticks(3);
    chk("adi_not_fetching", readM, 1'b0);
    tick();
    chk("fetch1_addr", {readM, address}, {1'b1, 16'h0001});
    chk("adi_retired", num_inst, 16'h1);
    ticks(2);
    chk("wwd_output", output_port, 16'h0005);
    chk("wwd_num_inst", num_inst, 16'h2);

    // Three wait cycles in FETCH
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_bus", {readM, writeM, address}, {2'b10, 16'h0002});
    end
    mem_ready = 1'b1;
    ticks(4);
    chk("adi_wait_done", {readM, address}, {1'b1, 16'h0003});

    // Branches
    ticks(3);
    chk("beq_taken", {readM, address}, {1'b1, 16'h0006});
    ticks(3);
    chk("bne_not_taken", {readM, address}, {1'b1, 16'h0007});
    ticks(2);
    chk("wwd_r2", output_port, 16'h0007);

    // Store then load back
    ticks(3);
    chk("swd_bus", {readM, writeM, address, data}, {2'b01, 16'h0010, 16'h0005});
    tick();
    chk("swd_done", {writeM, address}, {1'b0, 16'h0009});
    chk("swd_mem", mem[16'h0010], 16'h0005);
    ticks(3);
    chk("lwd_bus", {readM, writeM, address}, {2'b10, 16'h0010});
    ticks(2);
    chk("lwd_done", address, 16'h000A);
    ticks(2);
    chk("lwd_r2", output_port, 16'h0005);

    // JMP, LHI, NOT, NOP, HLT
    ticks(2);
    chk("jmp_fetch", {readM, address}, {1'b1, 16'h00A0});
    ticks(6);
    chk("lhi_output", output_port, 16'h1200);
    ticks(6);
    chk("not_output", output_port, 16'hEDFF);
    ticks(2);
    chk("nop_num_inst", num_inst, 16'h000F);
    ticks(2);
    chk("hlt_halted", is_halted, 1'b1);
    chk("hlt_num_inst", num_inst, 16'h0010);
    ticks(3);
    chk("halt_idle", {readM, writeM, is_halted, fault}, 4'b0010);
    chk("halt_frozen", num_inst, 16'h0010);

    // Wait timeout in FETCH
    reset = 1'b1;
    ticks(2);
    chk("rst2_halted", is_halted, 1'b0);
    reset = 1'b0;
    tick();
    mem_ready = 1'b0;
    ticks(7);
    chk("to_before", {readM, is_halted, fault}, 3'b100);
    tick();
    chk("to_fault", {readM, is_halted, fault}, 3'b011);
    chk("to_num_inst", num_inst, 16'h0);
    mem_ready = 1'b1;
    reset = 1'b1;
    tick();
    chk("to_reset", {is_halted, fault}, 2'b00);

    for (int p = 0; p < 4; p++) run_random(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
